execute_stage_mdu: RTL and testbench
====================================

// Module: execute_stage_mdu
// PURPOSE
//  Parametrised RV32/64 execute stage: operand forwarding, extended ALU, full branch compare,
//  JAL/JALR target generation and an iterative multiply/divide unit (MDU) that stalls the pipe.
//  Sits between the D/E register and the memory stage; owns the E/M pipeline register.
// PARAMETERS
//  XLEN    32  datapath width (32 or 64)
//  REGW    5   register-index width
//  MDU_EN  1   1 = M-extension ops executed by MDU; 0 = MDU removed, mdu_validE ignored
// PORTS
//  clk          in   1     rising-edge clock
//  rst          in   1     asynchronous, active-high reset
//  regwriteE    in   1     register write enable
//  memwriteE    in   1     memory write enable
//  resultsrcE   in   2     writeback result select
//  jumpE        in   1     JAL/JALR
//  jalrE        in   1     1 = target from srcA, not pcE
//  branchE      in   1     conditional branch
//  branchopE    in   3     funct3 branch condition
//  alucontrolE  in   4     ALU op (exec_pkg::alu_op_t)
//  alusrcE      in   1     1 = srcB is immextE
//  mdu_validE   in   1     instruction is an M-extension op
//  mduopE       in   3     funct3 MDU op
//  rd1E, rd2E   in   XLEN  register operands
//  pcE, immextE, pcplus4E in XLEN
//  rdE          in   REGW  destination register
//  forwardAE/BE in   2     00 reg, 01 resultW, 10 aluresultM, 11 reg
//  resultW      in   XLEN  writeback-stage result
//  pctargetE    out  XLEN  branch/jump target
//  pcsrcE       out  1     redirect fetch
//  busyE        out  1     MDU busy; hazard unit stalls F/D/E
//  regwriteM, memwriteM out 1; resultsrcM out 2; rdM out REGW
//  aluresultM, writedataM, pcplus4M out XLEN
// BEHAVIOUR
//  - srcA = fwdA mux; writedataE = fwdB mux; srcB = alusrcE ? immextE : writedataE.
//  - ALU: ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA, PASSB; undefined codes give 0.
//    Shift amount = srcB[$clog2(XLEN)-1:0]. Results are modulo 2^XLEN.
//  - Branch taken: 000 eq, 001 ne, 100 lt, 101 ge, 110 ltu, 111 geu; 010/011 never taken.
//  - pcsrcE = jumpE | (branchE & taken). This path is combinational and never blocked by busyE.
//  - pctargetE = jalrE ? (srcA+immextE) & ~1 : pcE+immextE.
//  - MDU FSM: IDLE -> RUN -> DONE -> IDLE.
//    - IDLE with mdu_validE: capture srcA/writedataE and op, cnt = XLEN-1, go RUN.
//    - RUN: one bit per cycle (shift-add multiply, restoring divide); at cnt == 0 go DONE.
//    - DONE: result valid, E/M register loads it; next edge returns to IDLE.
//  - busyE = mdu_validE & (state != DONE). Total E occupancy is XLEN+2 cycles, fixed.
//  - Signed ops divide magnitudes and sign-fix in DONE.
//    - MULH/MULHSU/MULHU return the upper XLEN bits; MUL returns the lower XLEN bits.
//  - Divide by zero: quotient all ones, remainder = dividend.
//  - Signed overflow (MIN / -1): quotient MIN, remainder 0.
//  - Both special cases are detected at capture; latency is unchanged.
//  - E/M register, first match applies:
//    1. rst: all outputs 0.
//    2. busyE: bubble (regwrite, memwrite, resultsrc, rd, aluresult, writedata, pcplus4 = 0).
//    3. Otherwise: load E values; aluresultM = MDU result when mdu_validE, else ALU result.
//  - Reset mid-operation: FSM to IDLE, counter and partial product/remainder cleared, busyE 0.
//  - MDU_EN = 0: no FSM, busyE tied 0, ALU result always used.
//  - Back-to-back MDU ops: IDLE is entered for one cycle between them; each op costs XLEN+2 cycles.
// STRUCTURE
//  - exec_pkg holds:
//    - alu_op_t (4b enum), br_op_t, mdu_op_t (3b enum);
//    - FWD_REG/FWD_W/FWD_M localparams;
//    - mdu_state_t {IDLE, RUN, DONE}.
//  - Sub-module iter_muldiv #(XLEN) holds the FSM, counter and datapath.
//    - Ports: clk, rst, start, op, a, b, busy, done, result.
//  - The ALU stays inline as an always_comb case.
// TESTING
//  - Forwarding with XLEN=32: rd1E=1, aluresultM=5, forwardAE=10, ADD imm=3 -> next-cycle aluresultM=8.
//  - Branches: BLT -1 vs 1 -> pcsrcE=1; BLTU 0xFFFFFFFF vs 1 -> 0.
//    JALR srcA=0x101, imm=4 -> pctargetE=0x104.
//  - MUL 7*-3: busyE high 33 cycles, bubbles in M during those cycles.
//    On cycle 34 aluresultM=0xFFFFFFEB. MULHU 0xFFFFFFFF^2 -> 0xFFFFFFFE.
//  - Divide edge cases: DIV 7/0 -> 0xFFFFFFFF; REM 7/0 -> 7; DIV 0x80000000/-1 -> 0x80000000; REM -> 0.
//  - Assert rst mid-RUN -> busyE=0 and all M outputs 0 immediately.
//    A fresh DIVU 100/7 after release -> 14 after 34 cycles.
//  - MDU_EN=0: mdu_validE=1 with ADD 2+2 -> busyE never high, aluresultM=4 next cycle.

Source files
------------

// File: rtl/exec_pkg.sv
// exec_pkg: shared encodings for the execute stage and its multiply/divide unit
package exec_pkg;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT,
    ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_PASSB
  } alu_op_t;
  typedef enum logic [2:0] {
    BR_EQ = 3'b000, BR_NE = 3'b001, BR_LT = 3'b100,
    BR_GE = 3'b101, BR_LTU = 3'b110, BR_GEU = 3'b111
  } br_op_t;
  typedef enum logic [2:0] {
    MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_MULHU,
    MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU
  } mdu_op_t;
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_W = 2'b01;
  localparam logic [1:0] FWD_M = 2'b10;
  typedef enum logic [1:0] {IDLE, RUN, DONE} mdu_state_t;
endpackage

// File: rtl/iter_muldiv.sv
// iter_muldiv: one-bit-per-cycle shift-add multiplier and restoring divider
module iter_muldiv
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  mdu_state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2*XLEN-1:0] p, prod;
  logic [XLEN-1:0] d, a_q, q_s, r_s, ma, mb;
  logic [XLEN:0] msum, rsh, rdiff;
  logic [2:0] op_q;
  logic na, nb, dz, ovf, na_c, nb_c;
  // operands are reduced to magnitudes at capture; signs are reapplied in DONE
  assign na_c = (op inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM}) & a[XLEN-1];
  assign nb_c = (op inside {MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM}) & b[XLEN-1];
  assign ma = na_c ? -a : a;
  assign mb = nb_c ? -b : b;
  // p holds {partial product, multiplier} or {remainder, quotient}
  assign msum = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, d} : '0);
  assign rsh = {p[2*XLEN-1:XLEN], p[XLEN-1]};
  assign rdiff = rsh - {1'b0, d};
  assign prod = (na ^ nb) ? -p : p;
  assign q_s = (na ^ nb) ? -p[XLEN-1:0] : p[XLEN-1:0];
  assign r_s = na ? -p[2*XLEN-1:XLEN] : p[2*XLEN-1:XLEN];
  assign result = !op_q[2] ? ((op_q == MDU_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]) :
                  !op_q[1] ? (dz ? '1 : ovf ? MIN : q_s) :
                  (dz ? a_q : ovf ? '0 : r_s);
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next state and status; busy drops in DONE so the result can retire
  always_comb begin
    state_n = state;
    busy = start & ~rst & (state != DONE);
    done = state == DONE;
    case (state)
      IDLE: state_n = start ? RUN : IDLE;
      RUN: state_n = (cnt == '0) ? DONE : RUN;
      default: state_n = IDLE;
    endcase
  end
  // datapath: capture in IDLE, one iteration per RUN cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {cnt, p, d, a_q, op_q, na, nb, dz, ovf} <= '0;
    end else if (state == IDLE && start) begin
      cnt <= CW'(XLEN - 1);
      p <= {{XLEN{1'b0}}, op[2] ? ma : mb};
      d <= op[2] ? mb : ma;
      a_q <= a;
      op_q <= op;
      na <= na_c;
      nb <= nb_c;
      dz <= b == '0;
      ovf <= (op == MDU_DIV || op == MDU_REM) && a == MIN && b == '1;
    end else if (state == RUN) begin
      cnt <= cnt - 1'b1;
      p <= !op_q[2] ? {msum, p[XLEN-1:1]} :
           rdiff[XLEN] ? {rsh[XLEN-1:0], p[XLEN-2:0], 1'b0} :
           {rdiff[XLEN-1:0], p[XLEN-2:0], 1'b1};
    end
endmodule

// File: rtl/execute_stage_mdu.sv
// execute_stage_mdu: forwarding, ALU, branch resolution, MDU and the E/M register
module execute_stage_mdu
  import exec_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REGW = 5,
  parameter bit MDU_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            regwriteE,
  input  logic            memwriteE,
  input  logic [1:0]      resultsrcE,
  input  logic            jumpE,
  input  logic            jalrE,
  input  logic            branchE,
  input  logic [2:0]      branchopE,
  input  logic [3:0]      alucontrolE,
  input  logic            alusrcE,
  input  logic            mdu_validE,
  input  logic [2:0]      mduopE,
  input  logic [XLEN-1:0] rd1E,
  input  logic [XLEN-1:0] rd2E,
  input  logic [XLEN-1:0] pcE,
  input  logic [XLEN-1:0] immextE,
  input  logic [XLEN-1:0] pcplus4E,
  input  logic [REGW-1:0] rdE,
  input  logic [1:0]      forwardAE,
  input  logic [1:0]      forwardBE,
  input  logic [XLEN-1:0] resultW,
  output logic [XLEN-1:0] pctargetE,
  output logic            pcsrcE,
  output logic            busyE,
  output logic            regwriteM,
  output logic            memwriteM,
  output logic [1:0]      resultsrcM,
  output logic [REGW-1:0] rdM,
  output logic [XLEN-1:0] aluresultM,
  output logic [XLEN-1:0] writedataM,
  output logic [XLEN-1:0] pcplus4M
);
  localparam int SW = $clog2(XLEN);
  logic [XLEN-1:0] src_a, src_b, writedata_e, alu_result, mdu_result, jalr_sum;
  logic [SW-1:0] shamt;
  logic taken, mdu_busy, mdu_done;
  assign src_a = (forwardAE == FWD_W) ? resultW : (forwardAE == FWD_M) ? aluresultM : rd1E;
  assign writedata_e = (forwardBE == FWD_W) ? resultW : (forwardBE == FWD_M) ? aluresultM : rd2E;
  assign src_b = alusrcE ? immextE : writedata_e;
  assign shamt = src_b[SW-1:0];
  assign jalr_sum = src_a + immextE;
  assign pctargetE = jalrE ? {jalr_sum[XLEN-1:1], 1'b0} : pcE + immextE;
  assign pcsrcE = jumpE | (branchE & taken);
  assign busyE = mdu_busy;
  // ALU; unassigned encodings produce zero
  always_comb begin
    alu_result = '0;
    case (alucontrolE)
      ALU_ADD: alu_result = src_a + src_b;
      ALU_SUB: alu_result = src_a - src_b;
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR: alu_result = src_a | src_b;
      ALU_XOR: alu_result = src_a ^ src_b;
      ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, src_a < src_b};
      ALU_SLL: alu_result = src_a << shamt;
      ALU_SRL: alu_result = src_a >> shamt;
      ALU_SRA: alu_result = $unsigned($signed(src_a) >>> shamt);
      ALU_PASSB: alu_result = src_b;
      default: alu_result = '0;
    endcase
  end
  // branch condition compares the two register operands
  always_comb begin
    taken = 1'b0;
    case (branchopE)
      BR_EQ: taken = src_a == writedata_e;
      BR_NE: taken = src_a != writedata_e;
      BR_LT: taken = $signed(src_a) < $signed(writedata_e);
      BR_GE: taken = $signed(src_a) >= $signed(writedata_e);
      BR_LTU: taken = src_a < writedata_e;
      BR_GEU: taken = src_a >= writedata_e;
      default: taken = 1'b0;
    endcase
  end
  if (MDU_EN) begin : g_mdu
    iter_muldiv #(.XLEN(XLEN)) u_mdu (
      .clk(clk), .rst(rst), .start(mdu_validE), .op(mduopE), .a(src_a), .b(writedata_e),
      .busy(mdu_busy), .done(mdu_done), .result(mdu_result)
    );
  end else begin : g_no_mdu
    assign mdu_busy = 1'b0;
    assign mdu_done = 1'b0;
    assign mdu_result = '0;
  end
  // E/M pipeline register; inserts bubbles while the MDU is iterating
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {regwriteM, memwriteM, resultsrcM, rdM, aluresultM, writedataM, pcplus4M} <= '0;
    end else if (busyE) begin
      {regwriteM, memwriteM, resultsrcM, rdM, aluresultM, writedataM, pcplus4M} <= '0;
    end else begin
      regwriteM <= regwriteE;
      memwriteM <= memwriteE;
      resultsrcM <= resultsrcE;
      rdM <= rdE;
      aluresultM <= (mdu_validE & mdu_done) ? mdu_result : alu_result;
      writedataM <= writedata_e;
      pcplus4M <= pcplus4E;
    end
endmodule

// File: tb/tb_execute_stage_mdu.sv
// tb_execute_stage_mdu: vector table for ALU/branch paths, directed MDU sequences
module tb_execute_stage_mdu;
  import exec_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  logic regwriteE, memwriteE, jumpE, jalrE, branchE, alusrcE, mdu_validE;
  logic [1:0] resultsrcE, forwardAE, forwardBE;
  logic [2:0] branchopE, mduopE;
  logic [3:0] alucontrolE;
  logic [31:0] rd1E, rd2E, pcE, immextE, pcplus4E, resultW;
  logic [4:0] rdE;
  logic [31:0] pctargetE, aluresultM, writedataM, pcplus4M;
  logic pcsrcE, busyE, regwriteM, memwriteM;
  logic [1:0] resultsrcM;
  logic [4:0] rdM;
  logic [31:0] n_pctargetE, n_aluresultM, n_writedataM, n_pcplus4M;
  logic n_pcsrcE, n_busyE, n_regwriteM, n_memwriteM;
  logic [1:0] n_resultsrcM;
  logic [4:0] n_rdM;
  int checks = 0, errors = 0;
  logic [31:0] exp_q[$];
  typedef struct {
    logic [3:0] alu; logic [31:0] a, b, imm; logic alusrc; logic [1:0] fa;
    logic br, jmp, jalr; logic [2:0] bop; logic [31:0] exp_alu; logic exp_pc; logic [31:0] exp_tgt;
  } vec_t;
  vec_t vecs[20];

  always #5 clk = ~clk;

  execute_stage_mdu #(.XLEN(32), .REGW(5), .MDU_EN(1'b1)) u0 (
    .clk(clk), .rst(rst), .regwriteE(regwriteE), .memwriteE(memwriteE), .resultsrcE(resultsrcE),
    .jumpE(jumpE), .jalrE(jalrE), .branchE(branchE), .branchopE(branchopE), .alucontrolE(alucontrolE),
    .alusrcE(alusrcE), .mdu_validE(mdu_validE), .mduopE(mduopE), .rd1E(rd1E), .rd2E(rd2E), .pcE(pcE),
    .immextE(immextE), .pcplus4E(pcplus4E), .rdE(rdE), .forwardAE(forwardAE), .forwardBE(forwardBE),
    .resultW(resultW), .pctargetE(pctargetE), .pcsrcE(pcsrcE), .busyE(busyE), .regwriteM(regwriteM),
    .memwriteM(memwriteM), .resultsrcM(resultsrcM), .rdM(rdM), .aluresultM(aluresultM),
    .writedataM(writedataM), .pcplus4M(pcplus4M));

  execute_stage_mdu #(.XLEN(32), .REGW(5), .MDU_EN(1'b0)) u1 (
    .clk(clk), .rst(rst), .regwriteE(regwriteE), .memwriteE(memwriteE), .resultsrcE(resultsrcE),
    .jumpE(jumpE), .jalrE(jalrE), .branchE(branchE), .branchopE(branchopE), .alucontrolE(alucontrolE),
    .alusrcE(alusrcE), .mdu_validE(mdu_validE), .mduopE(mduopE), .rd1E(rd1E), .rd2E(rd2E), .pcE(pcE),
    .immextE(immextE), .pcplus4E(pcplus4E), .rdE(rdE), .forwardAE(forwardAE), .forwardBE(forwardBE),
    .resultW(resultW), .pctargetE(n_pctargetE), .pcsrcE(n_pcsrcE), .busyE(n_busyE), .regwriteM(n_regwriteM),
    .memwriteM(n_memwriteM), .resultsrcM(n_resultsrcM), .rdM(n_rdM), .aluresultM(n_aluresultM),
    .writedataM(n_writedataM), .pcplus4M(n_pcplus4M));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic run_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string nm);
    int n;
    logic bad;
    n = 0;
    bad = 1'b0;
    mdu_validE = 1'b1; mduopE = op; rd1E = a; rd2E = b; alusrcE = 1'b0;
    forwardAE = 2'b00; forwardBE = 2'b00; alucontrolE = ALU_ADD; rdE = 5'd7;
    branchE = 1'b0; jumpE = 1'b0; jalrE = 1'b0;
    exp_q.push_back(exp);
    #1;
    while (busyE && n < 100) begin
      n++;
      @(posedge clk); #1;
      if ({regwriteM, memwriteM, resultsrcM, rdM, aluresultM, writedataM, pcplus4M} != '0) bad = 1'b1;
    end
    chk({nm, " busy_cycles"}, n, 33);
    chk({nm, " bubble"}, {31'b0, bad}, 32'd0);
    @(posedge clk); #1;
    chk({nm, " result"}, aluresultM, exp_q.pop_front());
    chk({nm, " rdM"}, {27'b0, rdM}, 32'd7);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{ALU_ADD,   32'd2,        32'd3,  32'd0,     1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 32'd5,        1'b0, 32'h1000};
    vecs[1]  = '{ALU_ADD,   32'd1,        32'd0,  32'd3,     1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 3'b000, 32'd8,        1'b0, 32'h1003};
    vecs[2]  = '{ALU_SUB,   32'd5,        32'd7,  32'd0,     1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 32'hFFFFFFFE, 1'b0, 32'h1000};
    vecs[3]  = '{ALU_AND,   32'hF0F0,     32'hFF00, 32'd0,   1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 32'hF000,     1'b0, 32'h1000};
    vecs[4]  = '{ALU_OR,    32'hF0F0,     32'h0F0F, 32'd0,   1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 32'hFFFF,     1'b0, 32'h1000};
    vecs[5]  = '{ALU_XOR,   32'hFF,       32'h0F, 32'd0,     1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 32'hF0,       1'b0, 32'h1000};
    vecs[6]  = '{ALU_SLT,   32'hFFFFFFFF, 32'd1,  32'h20,    1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 3'b100, 32'd1,        1'b1, 32'h1020};
    vecs[7]  = '{ALU_SLTU,  32'hFFFFFFFF, 32'd1,  32'h20,    1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 3'b110, 32'd0,        1'b0, 32'h1020};
    vecs[8]  = '{ALU_SLL,   32'd1,        32'd31, 32'd0,     1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 32'h80000000, 1'b0, 32'h1000};
    vecs[9]  = '{ALU_SRL,   32'h80000000, 32'd4,  32'd0,     1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 32'h08000000, 1'b0, 32'h1000};
    vecs[10] = '{ALU_SRA,   32'h80000000, 32'd4,  32'd0,     1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 32'hF8000000, 1'b0, 32'h1000};
    vecs[11] = '{ALU_SRL,   32'h100,      32'h24, 32'd0,     1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 32'h10,       1'b0, 32'h1000};
    vecs[12] = '{ALU_PASSB, 32'd0,        32'd0,  32'h1234,  1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 32'h1234,     1'b0, 32'h2234};
    vecs[13] = '{4'hF,      32'd5,        32'd5,  32'd0,     1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 32'd0,        1'b0, 32'h1000};
    vecs[14] = '{ALU_ADD,   32'h101,      32'd0,  32'd4,     1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 3'b000, 32'h105,      1'b1, 32'h104};
    vecs[15] = '{ALU_ADD,   32'd0,        32'd0,  32'd1,     1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 3'b000, 32'h101,      1'b0, 32'h1001};
    vecs[16] = '{ALU_SUB,   32'd9,        32'd9,  32'd0,     1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 3'b000, 32'd0,        1'b1, 32'h1000};
    vecs[17] = '{ALU_ADD,   32'd9,        32'd9,  32'd0,     1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 3'b010, 32'd18,       1'b0, 32'h1000};
    vecs[18] = '{ALU_ADD,   32'hFFFFFFFF, 32'd1,  32'd0,     1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 3'b101, 32'd0,        1'b0, 32'h1000};
    vecs[19] = '{ALU_ADD,   32'd8,        32'd9,  32'h40,    1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 3'b000, 32'd17,       1'b1, 32'h1040};
    regwriteE = 1'b1; memwriteE = 1'b0; resultsrcE = 2'b01; jumpE = 1'b0; jalrE = 1'b0;
    branchE = 1'b0; branchopE = 3'b000; alucontrolE = ALU_ADD; alusrcE = 1'b0;
    mdu_validE = 1'b0; mduopE = 3'b000; rd1E = '0; rd2E = '0; pcE = 32'h1000;
    immextE = '0; pcplus4E = 32'h1004; rdE = '0; forwardAE = 2'b00; forwardBE = 2'b00;
    resultW = 32'h100;
    repeat (2) @(posedge clk);
    #1;
    chk("reset aluresultM", aluresultM, 32'd0);
    chk("reset regwriteM", {31'b0, regwriteM}, 32'd0);
    chk("reset pcplus4M", pcplus4M, 32'd0);
    chk("reset busyE", {31'b0, busyE}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      alucontrolE = vecs[i].alu; rd1E = vecs[i].a; rd2E = vecs[i].b; immextE = vecs[i].imm;
      alusrcE = vecs[i].alusrc; forwardAE = vecs[i].fa; branchE = vecs[i].br;
      jumpE = vecs[i].jmp; jalrE = vecs[i].jalr; branchopE = vecs[i].bop; rdE = 5'(i + 1);
      exp_q.push_back(vecs[i].exp_alu);
      #1;
      chk($sformatf("vec%0d pcsrcE", i), {31'b0, pcsrcE}, {31'b0, vecs[i].exp_pc});
      chk($sformatf("vec%0d pctargetE", i), pctargetE, vecs[i].exp_tgt);
      @(posedge clk); #1;
      chk($sformatf("vec%0d aluresultM", i), aluresultM, exp_q.pop_front());
      chk($sformatf("vec%0d rdM", i), {27'b0, rdM}, i + 1);
    end
    chk("pcplus4M load", pcplus4M, 32'h1004);
    chk("writedataM load", writedataM, 32'd9);
    immextE = '0;
    run_mdu(MDU_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, "MUL 7*-3");
    run_mdu(MDU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "MULHU max");
    run_mdu(MDU_MULH, 32'h80000000, 32'h80000000, 32'h40000000, "MULH min*min");
    run_mdu(MDU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "MULHSU -1*max");
    run_mdu(MDU_DIV, 32'd7, 32'd0, 32'hFFFFFFFF, "DIV 7/0");
    run_mdu(MDU_REM, 32'd7, 32'd0, 32'd7, "REM 7/0");
    run_mdu(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "DIV min/-1");
    run_mdu(MDU_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, "REM min/-1");
    run_mdu(MDU_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, "DIV -7/2");
    run_mdu(MDU_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, "REM -7/2");
    run_mdu(MDU_REMU, 32'd100, 32'd7, 32'd2, "REMU 100/7");
    mdu_validE = 1'b1; mduopE = MDU_DIVU; rd1E = 32'd100; rd2E = 32'd7;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrun rst busyE", {31'b0, busyE}, 32'd0);
    chk("midrun rst regwriteM", {31'b0, regwriteM}, 32'd0);
    chk("midrun rst aluresultM", aluresultM, 32'd0);
    chk("midrun rst rdM", {27'b0, rdM}, 32'd0);
    mdu_validE = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    run_mdu(MDU_DIVU, 32'd100, 32'd7, 32'd14, "DIVU 100/7 after rst");
    mdu_validE = 1'b1; mduopE = MDU_MUL; alucontrolE = ALU_ADD; rd1E = 32'd2; rd2E = 32'd2; rdE = 5'd3;
    #1;
    chk("no_mdu busyE", {31'b0, n_busyE}, 32'd0);
    @(posedge clk); #1;
    chk("no_mdu aluresultM", n_aluresultM, 32'd4);
    chk("no_mdu regwriteM", {31'b0, n_regwriteM}, 32'd1);
    chk("no_mdu busyE later", {31'b0, n_busyE}, 32'd0);
    mdu_validE = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
